sram_memory_bank: RTL and testbench
===================================

Name: sram_memory_bank

Overview:
- Memory subsystem for the Bellman-Ford accelerator, holding three arrays behind one wrapper.
- Graph memory: read-only, two read ports, 128-bit words.
- Input memory: read-only, one read port, 8-bit words.
- Output memory: one read port plus one synchronous write port, 16-bit words.
- The graph and input arrays are preloaded by the bench; the output array is written by the accelerator and dumped by the bench at end of run.

Parameters:
- ADDR_W, 13, address width of every port.
- DEPTH, 8192, words per array.
- GM_W, 128, graph memory word width.
- IM_W, 8, input memory word width.
- OM_W, 16, output memory word width.

Ports:
- clock  in  1  rising-edge clock; used only by output-memory writes.
- reset  in  1  asynchronous, active-low; low clears the output array.
- gm_rd_addr1  in  ADDR_W  graph read address, port 1.
- gm_rd_data1  out  GM_W  graph read data, port 1.
- gm_rd_addr2  in  ADDR_W  graph read address, port 2.
- gm_rd_data2  out  GM_W  graph read data, port 2.
- im_rd_addr  in  ADDR_W  input read address.
- im_rd_data  out  IM_W  input read data.
- om_we  in  1  output write enable.
- om_wr_addr  in  ADDR_W  output write address.
- om_wr_data  in  OM_W  output write data.
- om_rd_addr  in  ADDR_W  output read address.
- om_rd_data  out  OM_W  output read data.

Behaviour:
- Every read port is purely combinational: data reflects the current address and array contents in the same delta cycle, with zero-cycle latency.
- The two graph ports are fully independent; equal addresses return identical data.
- Output write: at the rising edge of clock, when om_we=1 and reset=1, Register[om_wr_addr] takes om_wr_data. om_we=0 means no change.
- Read-during-write, same address: om_rd_data shows the old word before the edge and the new word immediately after it. There is no bypass.
- Reset low, asynchronous: every output-array word becomes 0 immediately. Writes are ignored while reset is low.
- Deassertion of reset is sampled on the next rising edge. A write with om_we=1 on the first edge with reset high takes effect.
- Reset does not touch the graph or input arrays. They keep their preloaded contents.
- Reset value of each output:
  - om_rd_data = 0.
  - gm_rd_data1/2 and im_rd_data = preloaded contents at the addressed location, or X if never loaded.
- Out-of-range addresses (address >= DEPTH, possible only when DEPTH < 2^ADDR_W): reads return 0 and writes are dropped.
- Each sub-array's storage is named Register, so $readmemh/$writememh work through hierarchical paths:
  - graph_mem.Register
  - input_mem.Register
  - output_mem.Register
- Instance names are graph_mem, input_mem and output_mem.
- No handshakes, no stalls, no X-propagation on the write port when om_we=0.

Decomposition:
- Shared package sram_pkg holds:
  - ADDR_W, DEPTH, GM_W, IM_W, OM_W defaults.
  - typedefs addr_t, gm_word_t, im_word_t, om_word_t.
- One sub-module, sram_array, parameterised by WIDTH, DEPTH, NUM_RD (1 or 2) and HAS_WR (0/1).
- sram_array contains the Register array, the combinational read muxes, out-of-range masking, and the write/clear process, which exists only when HAS_WR=1.
- sram_memory_bank instantiates sram_array three times:
  - 2R, 128-bit for graph_mem.
  - 1R, 8-bit for input_mem.
  - 1R1W, 16-bit for output_mem.

Test Plan:
- Preload graph_mem.Register[5]=128'hA5…A5 and [6]=128'h1234, set gm_rd_addr1=5 and gm_rd_addr2=6 -> gm_rd_data1=A5…A5 and gm_rd_data2=1234 in the same timestep. Swapping the addresses swaps the data with zero latency.
- Preload input_mem.Register[0]=8'h07 and [8191]=8'hFF, read addresses 0 then 8191 -> im_rd_data=07 then FF. Assert reset=0 -> im_rd_data is still FF.
- Hold reset=1, write om_wr_addr=3 with om_wr_data=16'hBEEF and om_we=1 for one edge, with om_rd_addr=3 -> om_rd_data goes from the old value to BEEF right after that edge. The next edge with om_we=0 and data 16'h0000 leaves it at BEEF.
- After writing 16'h1111 to address 10, drive reset=0 mid-cycle -> om_rd_data=0 immediately, without waiting for an edge. An edge with om_we=1 while reset=0 leaves Register[10]=0.
- Release reset and write address 10 with 16'h2222 on the first edge -> om_rd_data reads 2222. Then $writememh of output_mem.Register shows 2222 at line 10 and zeros elsewhere.
- With om_we held high, step om_wr_addr through 0..3 with data 1..4 on consecutive edges -> reading addresses 0..3 returns 1,2,3,4, and address 4 still reads 0.

Source files
------------

// File: rtl/sram_pkg.sv
// Shared widths and word types for the Bellman-Ford accelerator memory bank.
package sram_pkg;

  localparam int unsigned ADDR_W = 13;
  localparam int unsigned DEPTH  = 8192;
  localparam int unsigned GM_W   = 128;
  localparam int unsigned IM_W   = 8;
  localparam int unsigned OM_W   = 16;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [GM_W-1:0]   gm_word_t;
  typedef logic [IM_W-1:0]   im_word_t;
  typedef logic [OM_W-1:0]   om_word_t;

endpackage

// File: rtl/sram_memory_bank_if.sv
// Address/data bundle between the accelerator (master) and the memory bank (slave).
interface sram_memory_bank_if;
  import sram_pkg::*;

  addr_t    gm_rd_addr1;
  gm_word_t gm_rd_data1;
  addr_t    gm_rd_addr2;
  gm_word_t gm_rd_data2;
  addr_t    im_rd_addr;
  im_word_t im_rd_data;
  logic     om_we;
  addr_t    om_wr_addr;
  om_word_t om_wr_data;
  addr_t    om_rd_addr;
  om_word_t om_rd_data;

  modport master (
    output gm_rd_addr1, gm_rd_addr2, im_rd_addr,
    output om_we, om_wr_addr, om_wr_data, om_rd_addr,
    input  gm_rd_data1, gm_rd_data2, im_rd_data, om_rd_data
  );

  modport slave (
    input  gm_rd_addr1, gm_rd_addr2, im_rd_addr,
    input  om_we, om_wr_addr, om_wr_data, om_rd_addr,
    output gm_rd_data1, gm_rd_data2, im_rd_data, om_rd_data
  );

endinterface

// File: rtl/sram_array.sv
// Generic word array: NUM_RD combinational read ports, optional clocked write
// port with asynchronous clear. Storage is named Register for hierarchical preload/dump.
module sram_array #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DEPTH  = 8192,
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned NUM_RD = 1,
  parameter int unsigned HAS_WR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rd_addr [NUM_RD],
  output logic [WIDTH-1:0]  rd_data [NUM_RD],
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data
);

  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // When the array fills the whole address space no range check is needed.
  localparam bit FULL_MAP = (DEPTH >= (64'd1 << ADDR_W));

  logic [WIDTH-1:0] Register [DEPTH];

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic hit;
    if (FULL_MAP) begin : g_full
      assign hit = 1'b1;
    end else begin : g_part
      assign hit = rd_addr[i] < ADDR_W'(DEPTH);
    end
    assign rd_data[i] = hit ? Register[rd_addr[i][IDX_W-1:0]] : '0;
  end

  if (HAS_WR != 0) begin : g_wr
    logic wr_hit;
    if (FULL_MAP) begin : g_full
      assign wr_hit = 1'b1;
    end else begin : g_part
      assign wr_hit = wr_addr < ADDR_W'(DEPTH);
    end

    // Reset clears every word immediately; writes land on the rising edge only.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned k = 0; k < DEPTH; k++) begin
          Register[IDX_W'(k)] <= '0;
        end
      end else if (we && wr_hit) begin
        Register[wr_addr[IDX_W-1:0]] <= wr_data;
      end
    end
  end else begin : g_no_wr
    logic unused_wr;
    assign unused_wr = ^{clk, rst_n, we, wr_addr, wr_data};
  end

endmodule

// File: rtl/sram_memory_bank.sv
// Bellman-Ford memory subsystem: 2R graph array, 1R input array, 1R1W output array.
module sram_memory_bank
  import sram_pkg::*;
(
  input  logic                 clock,
  input  logic                 reset,
  sram_memory_bank_if.slave    bus
);

  addr_t    gm_addr [2];
  gm_word_t gm_data [2];
  addr_t    im_addr [1];
  im_word_t im_data [1];
  addr_t    om_addr [1];
  om_word_t om_data [1];

  assign gm_addr[0] = bus.gm_rd_addr1;
  assign gm_addr[1] = bus.gm_rd_addr2;
  assign im_addr[0] = bus.im_rd_addr;
  assign om_addr[0] = bus.om_rd_addr;

  assign bus.gm_rd_data1 = gm_data[0];
  assign bus.gm_rd_data2 = gm_data[1];
  assign bus.im_rd_data  = im_data[0];
  assign bus.om_rd_data  = om_data[0];

  sram_array #(
    .WIDTH (GM_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .NUM_RD (2), .HAS_WR (0)
  ) graph_mem (
    .clk     (clock),
    .rst_n   (reset),
    .rd_addr (gm_addr),
    .rd_data (gm_data),
    .we      (1'b0),
    .wr_addr ('0),
    .wr_data ('0)
  );

  sram_array #(
    .WIDTH (IM_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .NUM_RD (1), .HAS_WR (0)
  ) input_mem (
    .clk     (clock),
    .rst_n   (reset),
    .rd_addr (im_addr),
    .rd_data (im_data),
    .we      (1'b0),
    .wr_addr ('0),
    .wr_data ('0)
  );

  sram_array #(
    .WIDTH (OM_W), .DEPTH (DEPTH), .ADDR_W (ADDR_W), .NUM_RD (1), .HAS_WR (1)
  ) output_mem (
    .clk     (clock),
    .rst_n   (reset),
    .rd_addr (om_addr),
    .rd_data (om_data),
    .we      (bus.om_we),
    .wr_addr (bus.om_wr_addr),
    .wr_data (bus.om_wr_data)
  );

endmodule

// File: tb/tb_sram_memory_bank.sv
// Scoreboard bench for sram_memory_bank: stimulus queues expected words, a monitor compares.
module tb_sram_memory_bank;
  import sram_pkg::*;

  typedef enum int {P_GM1, P_GM2, P_IM, P_OM, P_DUMP} port_e;
  typedef struct {
    port_e        port;
    logic [127:0] exp;
    string        name;
  } exp_t;

  logic clock = 1'b0;
  logic reset;
  logic smp = 1'b0;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q [$];

  sram_memory_bank_if bus ();

  sram_memory_bank dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic expect_val(input port_e p, input logic [127:0] v, input string nm);
    exp_t e;
    e.port = p;
    e.exp  = v;
    e.name = nm;
    sb_q.push_back(e);
  endtask

  task automatic sample();
    smp = 1'b1;
    #1;
    smp = 1'b0;
  endtask

  // Monitor: drains the scoreboard whenever the stimulus marks outputs as settled.
  initial begin
    forever begin
      @(posedge smp);
      while (sb_q.size() > 0) begin
        exp_t         e;
        logic [127:0] act;
        e = sb_q.pop_front();
        case (e.port)
          P_GM1:   act = bus.gm_rd_data1;
          P_GM2:   act = bus.gm_rd_data2;
          P_IM:    act = 128'(bus.im_rd_data);
          P_OM:    act = 128'(bus.om_rd_data);
          default: begin
            int bad = 0;
            for (int k = 0; k < int'(DEPTH); k++) begin
              if (dut.output_mem.Register[k] !== ((k == 10) ? 16'h2222 : 16'h0000)) bad++;
            end
            act = 128'(bad);
          end
        endcase
        n_checks++;
        if (act !== e.exp) begin
          n_fail++;
          $display("FAIL %s: got %h expected %h", e.name, act, e.exp);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    reset            = 1'b0;
    bus.gm_rd_addr1  = '0;
    bus.gm_rd_addr2  = '0;
    bus.im_rd_addr   = '0;
    bus.om_we        = 1'b0;
    bus.om_wr_addr   = '0;
    bus.om_wr_data   = '0;
    bus.om_rd_addr   = '0;
    dut.graph_mem.Register[5]    = {16{8'hA5}};
    dut.graph_mem.Register[6]    = 128'h1234;
    dut.input_mem.Register[0]    = 8'h07;
    dut.input_mem.Register[8191] = 8'hFF;
    #1;
    expect_val(P_OM, 128'h0, "om_reset_value");
    sample();

    @(negedge clock);
    reset = 1'b1;

    // Graph ports: independent, zero latency, swap and equal addresses.
    bus.gm_rd_addr1 = 13'd5;
    bus.gm_rd_addr2 = 13'd6;
    #1;
    expect_val(P_GM1, {16{8'hA5}}, "gm1_addr5");
    expect_val(P_GM2, 128'h1234,   "gm2_addr6");
    sample();
    bus.gm_rd_addr1 = 13'd6;
    bus.gm_rd_addr2 = 13'd5;
    #1;
    expect_val(P_GM1, 128'h1234,   "gm1_swapped");
    expect_val(P_GM2, {16{8'hA5}}, "gm2_swapped");
    sample();
    bus.gm_rd_addr2 = 13'd6;
    #1;
    expect_val(P_GM1, 128'h1234, "gm1_equal_addr");
    expect_val(P_GM2, 128'h1234, "gm2_equal_addr");
    sample();

    // Input memory, first and last word.
    bus.im_rd_addr = 13'd0;
    #1;
    expect_val(P_IM, 128'h07, "im_addr0");
    sample();
    bus.im_rd_addr = 13'd8191;
    #1;
    expect_val(P_IM, 128'hFF, "im_addr8191");
    sample();

    // Write with read of same address: old word before the edge, new after.
    bus.om_rd_addr = 13'd3;
    @(negedge clock);
    bus.om_we      = 1'b1;
    bus.om_wr_addr = 13'd3;
    bus.om_wr_data = 16'hBEEF;
    #1;
    expect_val(P_OM, 128'h0, "om_no_bypass");
    sample();
    @(posedge clock); #1;
    expect_val(P_OM, 128'hBEEF, "om_write_beef");
    sample();
    @(negedge clock);
    bus.om_we      = 1'b0;
    bus.om_wr_data = 16'h0000;
    @(posedge clock); #1;
    expect_val(P_OM, 128'hBEEF, "om_we0_holds");
    sample();

    @(negedge clock);
    bus.om_we      = 1'b1;
    bus.om_wr_addr = 13'd10;
    bus.om_wr_data = 16'h1111;
    bus.om_rd_addr = 13'd10;
    @(posedge clock); #1;
    expect_val(P_OM, 128'h1111, "om_write_1111");
    sample();
    @(negedge clock);
    bus.om_we = 1'b0;

    // Mid-cycle asynchronous reset.
    #2;
    reset = 1'b0;
    #1;
    expect_val(P_OM,  128'h0,      "om_async_clear");
    expect_val(P_IM,  128'hFF,     "im_kept_in_reset");
    expect_val(P_GM1, 128'h1234,   "gm1_kept_in_reset");
    sample();
    bus.om_we      = 1'b1;
    bus.om_wr_data = 16'h3333;
    @(posedge clock); #1;
    expect_val(P_OM, 128'h0, "om_write_ignored_in_reset");
    sample();

    // First edge after release accepts a write.
    @(negedge clock);
    reset          = 1'b1;
    bus.om_wr_data = 16'h2222;
    @(posedge clock); #1;
    expect_val(P_OM,   128'h2222, "om_first_edge_write");
    expect_val(P_DUMP, 128'h0,    "om_dump_bad_words");
    sample();

    // Back-to-back writes to 0..3.
    @(negedge clock);
    for (int i = 0; i < 4; i++) begin
      bus.om_wr_addr = 13'(i);
      bus.om_wr_data = 16'(i + 1);
      @(negedge clock);
    end
    bus.om_we = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.om_rd_addr = 13'(i);
      #1;
      expect_val(P_OM, (i < 4) ? 128'(i + 1) : 128'h0, $sformatf("om_burst_addr%0d", i));
      sample();
    end

    for (int t = 0; t < 10 && sb_q.size() > 0; t++) #1;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
